// File: rtl/microsequencer_pkg.sv
// Shared definitions for the microsequencer: next-state encodings, condition bit
// indices and microword field positions so the ROM word is sliced in one place.
package microsequencer_pkg;

   typedef enum logic [2:0] {
      NS_INC  = 3'b000,
      NS_JUMP = 3'b001,
      NS_DEC  = 3'b010,
      NS_CBR  = 3'b011,
      NS_CDEC = 3'b100,
      NS_WAIT = 3'b101,
      NS_CALL = 3'b110,
      NS_RET  = 3'b111
   } ns_sel_e;

   localparam int COND_TRUE = 0;
   localparam int COND_MOC  = 1;
   localparam int COND_PASS = 2;

   // 45-bit microword layout: sequencing fields in the low bits, datapath control above
   localparam int UW_W        = 45;
   localparam int UW_NS_LSB   = 0;
   localparam int UW_NS_W     = 3;
   localparam int UW_CSEL_LSB = 3;
   localparam int UW_CSEL_W   = 3;
   localparam int UW_CINV_BIT = 6;
   localparam int UW_CR_LSB   = 7;
   localparam int UW_CR_W     = 7;
   localparam int UW_CTRL_LSB = 14;
   localparam int UW_CTRL_W   = 31;

endpackage

// File: rtl/usq_ret_stack.sv
// Microroutine return-address LIFO; top-of-stack is visible combinationally so a
// RET can redirect the sequencer in the same cycle.
module usq_ret_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 7
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic                      pop,
   input  logic [W-1:0]              push_data,
   output logic [W-1:0]              top_data,
   output logic [$clog2(DEPTH):0]    depth,
   output logic                      full,
   output logic                      empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   SP_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [W-1:0] stack_mem [DEPTH];
   logic [PW:0]  sp_q, sp_d;

   assign full     = (sp_q == (PW+1)'(DEPTH));
   assign empty    = (sp_q == '0);
   assign depth    = sp_q;
   assign top_data = stack_mem[sp_q[PW-1:0] - PTR_ONE];

   always_comb begin
      sp_d = sp_q;
      if (push && !full) begin
         sp_d = sp_q + SP_ONE;
      end else if (pop && !empty) begin
         sp_d = sp_q - SP_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full && !reset) begin
         stack_mem[sp_q[PW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/microsequencer.sv
// Next-address engine: registered microstore index, branch/decode mux, return
// stack control and a bounded wait on a selected condition.
module microsequencer
   import microsequencer_pkg::*;
#(
   parameter int            AW          = 7,
   parameter int            NCOND       = 8,
   parameter int            STACK_DEPTH = 4,
   parameter int            WAIT_LIMIT  = 255,
   parameter logic [AW-1:0] RESET_ADDR  = 7'h00,
   parameter logic [AW-1:0] TRAP_ADDR   = 7'h5F
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [2:0]                     ns_sel,
   input  logic [2:0]                     cond_sel,
   input  logic                           cond_inv,
   input  logic [AW-1:0]                  cr_addr,
   input  logic [NCOND-1:0]               cond_in,
   input  logic [AW-1:0]                  dec_addr,
   input  logic                           hold,
   output logic [AW-1:0]                  index,
   output logic [$clog2(STACK_DEPTH):0]   stk_depth,
   output logic                           stk_err,
   output logic                           wait_to
);
   localparam int            CW       = $clog2(WAIT_LIMIT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_LIMIT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] IDX_ONE  = AW'(1);

   logic [AW-1:0] index_q, index_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stk_err_q, stk_err_d;
   logic          wait_to_q, wait_to_d;
   logic          push, pop, stk_full, stk_empty;
   logic [AW-1:0] stk_top;
   logic [AW-1:0] inc;
   logic          c;

   assign inc = index_q + IDX_ONE;
   assign c   = cond_in[cond_sel] ^ cond_inv;

   always_comb begin
      index_d   = index_q;
      cnt_d     = '0;
      stk_err_d = stk_err_q;
      wait_to_d = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      if (hold) begin
         cnt_d = cnt_q;
      end else begin
         case (ns_sel_e'(ns_sel))
            NS_INC:  index_d = inc;
            NS_JUMP: index_d = cr_addr;
            NS_DEC:  index_d = dec_addr;
            NS_CBR:  index_d = c ? cr_addr : inc;
            NS_CDEC: index_d = c ? cr_addr : dec_addr;
            NS_WAIT: begin
               if (c) begin
                  index_d = inc;
               end else if (cnt_q == CNT_LAST) begin
                  // Timeout leaves the return stack untouched
                  index_d   = TRAP_ADDR;
                  wait_to_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            NS_CALL: begin
               index_d = cr_addr;
               if (stk_full) stk_err_d = 1'b1;
               else          push      = 1'b1;
            end
            NS_RET: begin
               if (stk_empty) begin
                  index_d   = RESET_ADDR;
                  stk_err_d = 1'b1;
               end else begin
                  index_d = stk_top;
                  pop     = 1'b1;
               end
            end
            default: index_d = inc;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         index_q   <= RESET_ADDR;
         cnt_q     <= '0;
         stk_err_q <= 1'b0;
         wait_to_q <= 1'b0;
      end else begin
         index_q   <= index_d;
         cnt_q     <= cnt_d;
         stk_err_q <= stk_err_d;
         wait_to_q <= wait_to_d;
      end
   end

   usq_ret_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (AW)
   ) u_ret_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (inc),
      .top_data  (stk_top),
      .depth     (stk_depth),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   assign index   = index_q;
   assign stk_err = stk_err_q;
   assign wait_to = wait_to_q;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench: directed vector table, hand-written timeout/reset sequences
// and a randomized run against an array-based reference model.
module tb_microsequencer;

   logic       clk = 1'b0;
   logic       reset, hold, cond_inv;
   logic [2:0] ns_sel, cond_sel;
   logic [6:0] cr_addr, dec_addr;
   logic [7:0] cond_in;

   logic [6:0] index_a, index_b;
   logic [2:0] depth_a, depth_b;
   logic       err_a, err_b, wto_a, wto_b;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   microsequencer #(.WAIT_LIMIT(255)) dut_a (
      .clk(clk), .reset(reset), .ns_sel(ns_sel), .cond_sel(cond_sel), .cond_inv(cond_inv),
      .cr_addr(cr_addr), .cond_in(cond_in), .dec_addr(dec_addr), .hold(hold),
      .index(index_a), .stk_depth(depth_a), .stk_err(err_a), .wait_to(wto_a)
   );

   microsequencer #(.WAIT_LIMIT(4)) dut_b (
      .clk(clk), .reset(reset), .ns_sel(ns_sel), .cond_sel(cond_sel), .cond_inv(cond_inv),
      .cr_addr(cr_addr), .cond_in(cond_in), .dec_addr(dec_addr), .hold(hold),
      .index(index_b), .stk_depth(depth_b), .stk_err(err_b), .wait_to(wto_b)
   );

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] ns, input logic [2:0] cs, input logic inv,
                        input logic [7:0] cin, input logic [6:0] cr, input logic [6:0] dec,
                        input logic hd);
      ns_sel = ns; cond_sel = cs; cond_inv = inv; cond_in = cin;
      cr_addr = cr; dec_addr = dec; hold = hd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [2:0] ns;
      logic [2:0] cs;
      logic       inv;
      logic [7:0] cin;
      logic [6:0] cr;
      logic [6:0] dec;
      logic       hd;
      logic [6:0] e_idx;
      logic [2:0] e_dep;
      logic       e_err;
      logic       e_wto;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [2:0] ns, input logic [2:0] cs, input logic inv,
                               input logic [7:0] cin, input logic [6:0] cr, input logic [6:0] dec,
                               input logic hd, input logic [6:0] ei, input logic [2:0] ed,
                               input logic ee, input logic ew);
      vec_t v;
      v.ns = ns; v.cs = cs; v.inv = inv; v.cin = cin; v.cr = cr; v.dec = dec; v.hd = hd;
      v.e_idx = ei; v.e_dep = ed; v.e_err = ee; v.e_wto = ew;
      return v;
   endfunction

   // Reference model: plain integers, stack as an array, one entry per DUT instance
   int m_idx[2], m_dep[2], m_err[2], m_cnt[2], m_wto[2];
   int m_stk[2][4];

   task automatic model_step(input int k, input int lim);
      int c, inc;
      if (reset) begin
         m_idx[k] = 0; m_dep[k] = 0; m_err[k] = 0; m_cnt[k] = 0; m_wto[k] = 0;
         return;
      end
      m_wto[k] = 0;
      if (hold) return;
      c   = ((int'(cond_in) >> cond_sel) & 1) ^ int'(cond_inv);
      inc = (m_idx[k] + 1) % 128;
      if (ns_sel != 3'd5) m_cnt[k] = 0;
      case (ns_sel)
         3'd0: m_idx[k] = inc;
         3'd1: m_idx[k] = int'(cr_addr);
         3'd2: m_idx[k] = int'(dec_addr);
         3'd3: m_idx[k] = c ? int'(cr_addr) : inc;
         3'd4: m_idx[k] = c ? int'(cr_addr) : int'(dec_addr);
         3'd5: begin
            if (c != 0) begin
               m_idx[k] = inc; m_cnt[k] = 0;
            end else if (m_cnt[k] == lim - 1) begin
               m_idx[k] = 'h5F; m_wto[k] = 1; m_cnt[k] = 0;
            end else begin
               m_cnt[k]++;
            end
         end
         3'd6: begin
            if (m_dep[k] == 4) m_err[k] = 1;
            else begin
               m_stk[k][m_dep[k]] = inc; m_dep[k]++;
            end
            m_idx[k] = int'(cr_addr);
         end
         default: begin
            if (m_dep[k] == 0) begin
               m_idx[k] = 0; m_err[k] = 1;
            end else begin
               m_dep[k]--; m_idx[k] = m_stk[k][m_dep[k]];
            end
         end
      endcase
   endtask

   initial begin
      reset = 1'b1;
      drive(3'd0, 3'd0, 1'b0, 8'h01, 7'h00, 7'h00, 1'b0);
      step(); step();
      check("reset index", index_a, 0);
      check("reset depth", depth_a, 0);
      check("reset stk_err", err_a, 0);
      check("reset wait_to", wto_a, 0);
      check("reset index b", index_b, 0);
      reset = 1'b0;

      tbl.push_back(mk(0,0,0,8'h01,7'h00,7'h00,0, 7'h01,0,0,0));
      tbl.push_back(mk(0,0,0,8'h01,7'h00,7'h00,0, 7'h02,0,0,0));
      tbl.push_back(mk(0,0,0,8'h01,7'h00,7'h00,0, 7'h03,0,0,0));
      tbl.push_back(mk(1,0,0,8'h01,7'h7F,7'h00,0, 7'h7F,0,0,0));
      tbl.push_back(mk(0,0,0,8'h01,7'h00,7'h00,0, 7'h00,0,0,0));
      tbl.push_back(mk(3,2,0,8'h05,7'h28,7'h00,0, 7'h28,0,0,0));
      tbl.push_back(mk(3,2,0,8'h01,7'h28,7'h00,0, 7'h29,0,0,0));
      tbl.push_back(mk(3,2,1,8'h05,7'h28,7'h00,0, 7'h2A,0,0,0));
      tbl.push_back(mk(3,2,1,8'h01,7'h28,7'h00,0, 7'h28,0,0,0));
      tbl.push_back(mk(2,0,0,8'h01,7'h00,7'h0A,0, 7'h0A,0,0,0));
      tbl.push_back(mk(1,0,0,8'h01,7'h52,7'h00,0, 7'h52,0,0,0));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(5,1,0,8'h01,7'h00,7'h00,0, 7'h52,0,0,0));
      tbl.push_back(mk(5,1,0,8'h03,7'h00,7'h00,0, 7'h53,0,0,0));
      tbl.push_back(mk(1,0,0,8'h01,7'h10,7'h00,0, 7'h10,0,0,0));
      tbl.push_back(mk(6,0,0,8'h01,7'h30,7'h00,0, 7'h30,1,0,0));
      tbl.push_back(mk(6,0,0,8'h01,7'h40,7'h00,0, 7'h40,2,0,0));
      tbl.push_back(mk(7,0,0,8'h01,7'h00,7'h00,0, 7'h31,1,0,0));
      tbl.push_back(mk(7,0,0,8'h01,7'h00,7'h00,0, 7'h11,0,0,0));
      tbl.push_back(mk(1,0,0,8'h01,7'h77,7'h00,1, 7'h11,0,0,0));
      tbl.push_back(mk(4,0,0,8'h01,7'h22,7'h33,0, 7'h22,0,0,0));
      tbl.push_back(mk(4,0,1,8'h01,7'h22,7'h33,0, 7'h33,0,0,0));
      tbl.push_back(mk(6,0,0,8'h01,7'h60,7'h00,0, 7'h60,1,0,0));
      tbl.push_back(mk(6,0,0,8'h01,7'h61,7'h00,0, 7'h61,2,0,0));
      tbl.push_back(mk(6,0,0,8'h01,7'h62,7'h00,0, 7'h62,3,0,0));
      tbl.push_back(mk(6,0,0,8'h01,7'h63,7'h00,0, 7'h63,4,0,0));
      tbl.push_back(mk(6,0,0,8'h01,7'h64,7'h00,0, 7'h64,4,1,0));
      tbl.push_back(mk(7,0,0,8'h01,7'h00,7'h00,0, 7'h63,3,1,0));
      tbl.push_back(mk(7,0,0,8'h01,7'h00,7'h00,0, 7'h62,2,1,0));
      tbl.push_back(mk(7,0,0,8'h01,7'h00,7'h00,0, 7'h61,1,1,0));
      tbl.push_back(mk(7,0,0,8'h01,7'h00,7'h00,0, 7'h34,0,1,0));
      tbl.push_back(mk(7,0,0,8'h01,7'h00,7'h00,0, 7'h00,0,1,0));

      foreach (tbl[i]) begin
         drive(tbl[i].ns, tbl[i].cs, tbl[i].inv, tbl[i].cin, tbl[i].cr, tbl[i].dec, tbl[i].hd);
         step();
         check($sformatf("tbl[%0d] index", i), index_a, tbl[i].e_idx);
         check($sformatf("tbl[%0d] depth", i), depth_a, tbl[i].e_dep);
         check($sformatf("tbl[%0d] stk_err", i), err_a, tbl[i].e_err);
         check($sformatf("tbl[%0d] wait_to", i), wto_a, tbl[i].e_wto);
      end

      // Reset asserted together with hold in the middle of a call sequence
      drive(3'd6, 3'd0, 1'b0, 8'h01, 7'h10, 7'h00, 1'b0); step();
      drive(3'd6, 3'd0, 1'b0, 8'h01, 7'h20, 7'h00, 1'b0); step();
      check("pre-reset depth", depth_a, 2);
      reset = 1'b1;
      drive(3'd6, 3'd0, 1'b0, 8'h01, 7'h30, 7'h00, 1'b1); step();
      check("reset+hold index", index_a, 0);
      check("reset+hold depth", depth_a, 0);
      check("reset+hold stk_err", err_a, 0);
      reset = 1'b0;

      // Timeout on the WAIT_LIMIT=4 instance
      drive(3'd1, 3'd0, 1'b0, 8'h01, 7'h52, 7'h00, 1'b0); step();
      drive(3'd5, 3'd1, 1'b0, 8'h01, 7'h00, 7'h00, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         step();
         check($sformatf("wait%0d index_b", i), index_b, 'h52);
         check($sformatf("wait%0d wait_to_b", i), wto_b, 0);
      end
      step();
      check("timeout index_b", index_b, 'h5F);
      check("timeout wait_to_b", wto_b, 1);
      check("no timeout index_a", index_a, 'h52);
      check("no timeout wait_to_a", wto_a, 0);
      drive(3'd0, 3'd0, 1'b0, 8'h01, 7'h00, 7'h00, 1'b0); step();
      check("after timeout index_b", index_b, 'h60);
      check("after timeout wait_to_b", wto_b, 0);

      // Hold freezes the wait counter mid-wait
      drive(3'd1, 3'd0, 1'b0, 8'h01, 7'h52, 7'h00, 1'b0); step();
      drive(3'd5, 3'd1, 1'b0, 8'h01, 7'h00, 7'h00, 1'b0); step(); step();
      hold = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check("hold wait index_b", index_b, 'h52);
      hold = 1'b0;
      step();
      check("resume wait index_b", index_b, 'h52);
      step();
      check("resume timeout index_b", index_b, 'h5F);
      check("resume timeout wait_to_b", wto_b, 1);

      // Randomized run against the reference model
      for (int n = 0; n < 3000; n++) begin
         int r;
         r        = $urandom_range(0, 9);
         ns_sel   = (r > 7) ? 3'd5 : 3'(r);
         cond_sel = (ns_sel == 3'd5 && $urandom_range(0, 3) != 0) ? 3'd1 : 3'($urandom_range(0, 7));
         cond_inv = ($urandom_range(0, 3) == 0);
         cond_in  = 8'($urandom_range(0, 255)) | 8'h01;
         if (cond_sel == 3'd1) cond_in[1] = ($urandom_range(0, 3) == 0);
         cr_addr  = 7'($urandom_range(0, 127));
         dec_addr = 7'($urandom_range(0, 127));
         hold     = ($urandom_range(0, 7) == 0);
         reset    = (n == 0) || ($urandom_range(0, 199) == 0);
         model_step(0, 255);
         model_step(1, 4);
         step();
         check($sformatf("rnd[%0d] index_a", n), index_a, m_idx[0]);
         check($sformatf("rnd[%0d] depth_a", n), depth_a, m_dep[0]);
         check($sformatf("rnd[%0d] stk_err_a", n), err_a, m_err[0]);
         check($sformatf("rnd[%0d] wait_to_a", n), wto_a, m_wto[0]);
         check($sformatf("rnd[%0d] index_b", n), index_b, m_idx[1]);
         check($sformatf("rnd[%0d] depth_b", n), depth_b, m_dep[1]);
         check($sformatf("rnd[%0d] stk_err_b", n), err_b, m_err[1]);
         check($sformatf("rnd[%0d] wait_to_b", n), wto_b, m_wto[1]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
